// File: rtl/lutram_dump_reader.sv
// Read-side dump sequencer for a distributed-RAM RegFile: walks (base, count)
// through one async read port and streams {addr, data, last} via a 2-entry skid buffer.
module lutram_dump_reader #(
    parameter int unsigned addr_width = 5,
    parameter int unsigned data_width = 32,
    parameter int          lo         = 0,
    parameter int          hi         = 31
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [addr_width-1:0] REQ_BASE,
    input  logic [addr_width:0]   REQ_COUNT,
    output logic [addr_width-1:0] RAM_ADDR,
    input  logic [data_width-1:0] RAM_DATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [addr_width-1:0] RSP_ADDR,
    output logic [data_width-1:0] RSP_DATA,
    output logic                  RSP_LAST,
    output logic                  BUSY
);

    localparam int unsigned AW    = addr_width;
    localparam int unsigned CW    = addr_width + 1;
    localparam int unsigned DW    = data_width;
    localparam int unsigned DEPTH = hi - lo + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LO_C    = AW'(lo);
    localparam logic [AW-1:0] HI_C    = AW'(hi);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   ptr;
    logic [CW-1:0]   rem;

    // Tail slot of the skid buffer; the head slot is the RSP_* output registers.
    logic            t_valid;
    logic [AW-1:0]   t_addr;
    logic [DW-1:0]   t_data;
    logic            t_last;

    logic            accept;
    logic            pop;
    logic            issue;
    logic            base_ok;
    logic [AW-1:0]   base_eff;
    logic [CW-1:0]   count_eff;
    logic            new_last;

    assign RAM_ADDR = ptr;

    // Request qualification, issue decision and next state.
    always_comb begin
        state_nxt = state;
        accept    = REQ_VALID && REQ_READY;
        pop       = RSP_VALID && RSP_READY;
        issue     = (state == RUN) && (!t_valid || pop);
        new_last  = (rem == CW'(1));
        base_ok   = (int'(REQ_BASE) >= lo) && (int'(REQ_BASE) <= hi);
        base_eff  = base_ok ? REQ_BASE : LO_C;
        count_eff = (REQ_COUNT > DEPTH_C) ? DEPTH_C : REQ_COUNT;

        case (state)
            IDLE: begin
                if (accept && (count_eff != '0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (issue && new_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && !t_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer/remaining counters, status flags and skid buffer.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            REQ_READY <= 1'b1;
            BUSY      <= 1'b0;
            ptr       <= LO_C;
            rem       <= '0;
            RSP_VALID <= 1'b0;
            RSP_ADDR  <= '0;
            RSP_DATA  <= '0;
            RSP_LAST  <= 1'b0;
            t_valid   <= 1'b0;
            t_addr    <= '0;
            t_data    <= '0;
            t_last    <= 1'b0;
        end else begin
            REQ_READY <= (state_nxt == IDLE);
            BUSY      <= (state_nxt != IDLE);

            if (accept) begin
                ptr <= base_eff;
                rem <= count_eff;
            end else if (issue) begin
                ptr <= (ptr == HI_C) ? LO_C : ptr + AW'(1);
                rem <= rem - CW'(1);
            end

            if (pop) begin
                if (t_valid) begin
                    RSP_ADDR <= t_addr;
                    RSP_DATA <= t_data;
                    RSP_LAST <= t_last;
                    if (issue) begin
                        t_addr <= ptr;
                        t_data <= RAM_DATA;
                        t_last <= new_last;
                    end else begin
                        t_valid <= 1'b0;
                    end
                end else if (issue) begin
                    RSP_ADDR <= ptr;
                    RSP_DATA <= RAM_DATA;
                    RSP_LAST <= new_last;
                end else begin
                    RSP_VALID <= 1'b0;
                end
            end else if (issue) begin
                if (!RSP_VALID) begin
                    RSP_VALID <= 1'b1;
                    RSP_ADDR  <= ptr;
                    RSP_DATA  <= RAM_DATA;
                    RSP_LAST  <= new_last;
                end else begin
                    t_valid <= 1'b1;
                    t_addr  <= ptr;
                    t_data  <= RAM_DATA;
                    t_last  <= new_last;
                end
            end
        end
    end

endmodule
